// File: rtl/ova_pkg.sv
// Shared types and elaboration helpers for the overlap-add streaming accumulator.
package ova_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } ova_state_e;

  // Edge length of the overlap-added output for nb tiles of the given size.
  function automatic int ova_out_dim(input int nb, input int size, input int ovl);
    return nb * (size - ovl) + ovl;
  endfunction

  // Bits needed to count 0..n-1 (never less than one).
  function automatic int ova_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ova_sat_add.sv
// Signed adder with optional clamping; ovf flags any result outside the DATA_W range.
module ova_sat_add #(
  parameter int DATA_W   = 32,
  parameter int SATURATE = 1
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] sum,
  output logic                     ovf
);

  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] wide;

  always_comb begin
    wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // The two top bits differ exactly when the true sum left the signed range.
    ovf  = wide[DATA_W] ^ wide[DATA_W-1];
    sum  = wide[DATA_W-1:0];
    if (SATURATE != 0 && ovf) begin
      sum = wide[DATA_W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/ova_stream.sv
// Streams a grid of square tiles into an overlap-add buffer, then drains the
// finished matrix row-major before accepting the next frame.
module ova_stream
  import ova_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SIZE     = 4,
  parameter int OVERLAP  = 1,
  parameter int NB_ROWS  = 4,
  parameter int NB_COLS  = 4,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_tile_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     sat_err,
  output logic                     sync_err
);

  localparam int STRIDE = SIZE - OVERLAP;
  localparam int OUT_H  = ova_out_dim(NB_ROWS, SIZE, OVERLAP);
  localparam int OUT_W  = ova_out_dim(NB_COLS, SIZE, OVERLAP);
  localparam int CW     = ova_cnt_w(SIZE);
  localparam int BRW    = ova_cnt_w(NB_ROWS);
  localparam int BCW    = ova_cnt_w(NB_COLS);
  localparam int HW     = ova_cnt_w(OUT_H);
  localparam int WW     = ova_cnt_w(OUT_W);

  if (OVERLAP >= SIZE || OVERLAP < 0) begin : g_bad_overlap
    $error("ova_stream: OVERLAP must be in [0, SIZE)");
  end

  ova_state_e state;

  logic [CW-1:0]  r, c;
  logic [BRW-1:0] br;
  logic [BCW-1:0] bc;
  logic [HW-1:0]  orow, wr_row;
  logic [WW-1:0]  ocol, wr_col;

  logic signed [DATA_W-1:0] acc_buf [OUT_H][OUT_W];
  logic signed [DATA_W-1:0] add_sum;
  logic                     add_ovf;

  logic in_fire, out_fire;
  logic c_end, r_end, bc_end, br_end, tile_end;
  logic ocol_end, orow_end;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign c_end    = (c == CW'(SIZE - 1));
  assign r_end    = (r == CW'(SIZE - 1));
  assign bc_end   = (bc == BCW'(NB_COLS - 1));
  assign br_end   = (br == BRW'(NB_ROWS - 1));
  assign tile_end = c_end & r_end;
  assign ocol_end = (ocol == WW'(OUT_W - 1));
  assign orow_end = (orow == HW'(OUT_H - 1));

  assign out_last = out_valid & ocol_end & orow_end;

  // Tile-local position shifted by the tile origin on the stride grid.
  assign wr_row = HW'(br) * HW'(STRIDE) + HW'(r);
  assign wr_col = WW'(bc) * WW'(STRIDE) + WW'(c);

  assign out_data = acc_buf[orow][ocol];

  ova_sat_add #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (acc_buf[wr_row][wr_col]),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Drain zeroes each entry as it leaves, so the next frame starts from a clean buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_H; i++) begin
        for (int j = 0; j < OUT_W; j++) begin
          acc_buf[i][j] <= '0;
        end
      end
    end else if (in_fire) begin
      acc_buf[wr_row][wr_col] <= add_sum;
    end else if (out_fire) begin
      acc_buf[orow][ocol] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      r        <= '0;
      c        <= '0;
      br       <= '0;
      bc       <= '0;
      orow     <= '0;
      ocol     <= '0;
      sat_err  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            if (add_ovf) sat_err <= 1'b1;
            // The internal count is authoritative; a stray tile_last only flags.
            if (in_tile_last != tile_end) sync_err <= 1'b1;
            if (c_end) begin
              c <= '0;
              if (r_end) begin
                r <= '0;
                if (bc_end) begin
                  bc <= '0;
                  if (br_end) begin
                    br    <= '0;
                    state <= DRAIN;
                  end else begin
                    br <= br + BRW'(1);
                  end
                end else begin
                  bc <= bc + BCW'(1);
                end
              end else begin
                r <= r + CW'(1);
              end
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (ocol_end) begin
              ocol <= '0;
              if (orow_end) begin
                orow     <= '0;
                state    <= ACCUM;
                sat_err  <= 1'b0;
                sync_err <= 1'b0;
              end else begin
                orow <= orow + HW'(1);
              end
            end else begin
              ocol <= ocol + WW'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
